// File: rtl/iter_muldiv_unit.sv
// iter_muldiv_unit
//   Iterative unsigned multiply/divide unit. One radix-2 step per clock:
//   shift-add multiply or restoring divide. Results go to the register file
//   write port.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   start             request a new operation (only sampled in IDLE)
//   op                00 MUL lo, 01 MULH hi, 10 DIVU quotient, 11 REMU remainder
//   operand_a/_b      multiplicand/dividend, multiplier/divisor
//   dest_reg          destination register index, returned as result_reg
//   busy              high in RUN and DONE
//   done, result_we   one-cycle completion pulse / register-file write strobe
//   result            final value, held until the next completion
//   result_reg        dest_reg of the completed operation
module iter_muldiv_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [1:0]                op,
  input  logic [DATA_WIDTH-1:0]     operand_a,
  input  logic [DATA_WIDTH-1:0]     operand_b,
  input  logic [REG_ADDR_WIDTH-1:0] dest_reg,
  output logic                      busy,
  output logic                      done,
  output logic [DATA_WIDTH-1:0]     result,
  output logic [REG_ADDR_WIDTH-1:0] result_reg,
  output logic                      result_we
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [1:0]                op_q, op_d;
  logic [REG_ADDR_WIDTH-1:0] dest_q, dest_d;
  // opnd: multiplicand (MUL/MULH) or divisor (DIVU/REMU)
  logic [W-1:0]              opnd_q, opnd_d;
  // acc: upper product half / partial remainder (one spare bit for carry)
  logic [W:0]                acc_q, acc_d;
  // lo: lower product half (multiplier bits shift out) / dividend->quotient
  logic [W-1:0]              lo_q, lo_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic [W-1:0]              result_q, result_d;
  logic [REG_ADDR_WIDTH-1:0] result_reg_q, result_reg_d;

  logic [W:0] mul_sum;
  logic [W:0] div_shift;
  logic [W:0] div_trial;

  always_comb begin
    mul_sum   = acc_q + {1'b0, opnd_q};
    div_shift = {acc_q[W-1:0], lo_q[W-1]};
    // Bit W of the trial difference is the borrow: set when shift < divisor.
    div_trial = div_shift - {1'b0, opnd_q};

    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    dest_d       = dest_q;
    opnd_d       = opnd_q;
    acc_d        = acc_q;
    lo_d         = lo_q;
    busy_d       = busy_q;
    done_d       = done_q;
    result_d     = result_q;
    result_reg_d = result_reg_q;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        done_d = 1'b0;
        if (start) begin
          state_d = S_RUN;
          busy_d  = 1'b1;
          op_d    = op;
          dest_d  = dest_reg;
          cnt_d   = CNT_W'(W - 1);
          acc_d   = '0;
          opnd_d  = op[1] ? operand_b : operand_a;
          lo_d    = op[1] ? operand_a : operand_b;
        end
      end

      S_RUN: begin
        busy_d = 1'b1;
        done_d = 1'b0;
        if (op_q[1]) begin
          // Restoring divide: keep the difference only when it did not borrow.
          // A zero divisor never borrows, giving all-ones quotient and
          // remainder = dividend without special casing.
          if (!div_trial[W]) begin
            acc_d = div_trial;
            lo_d  = {lo_q[W-2:0], 1'b1};
          end else begin
            acc_d = div_shift;
            lo_d  = {lo_q[W-2:0], 1'b0};
          end
        end else begin
          // Shift-add multiply: add multiplicand into the upper half when the
          // current multiplier LSB is set, then shift the whole product right.
          if (lo_q[0]) begin
            acc_d = {1'b0, mul_sum[W:1]};
            lo_d  = {mul_sum[0], lo_q[W-1:1]};
          end else begin
            acc_d = {1'b0, acc_q[W:1]};
            lo_d  = {acc_q[0], lo_q[W-1:1]};
          end
        end

        if (cnt_q == '0) begin
          state_d      = S_DONE;
          done_d       = 1'b1;
          // op[0] picks the acc half: MULH high product / REMU remainder.
          result_d     = op_q[0] ? acc_d[W-1:0] : lo_d;
          result_reg_d = dest_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      op_q         <= '0;
      dest_q       <= '0;
      opnd_q       <= '0;
      acc_q        <= '0;
      lo_q         <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      result_q     <= '0;
      result_reg_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      dest_q       <= dest_d;
      opnd_q       <= opnd_d;
      acc_q        <= acc_d;
      lo_q         <= lo_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      result_q     <= result_d;
      result_reg_q <= result_reg_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign result_we  = done_q;
  assign result     = result_q;
  assign result_reg = result_reg_q;

endmodule
